// File: rtl/prism_sp_puzzle_hw_gem_dma_read.sv
// ---------------------------------------------------------------------------
// prism_sp_puzzle_hw_gem_dma_read
//
// TX-side DMA sequencer for the GEM puzzle path. It pops one TX cookie at a
// time and checks the frame length. Valid frames get a meta descriptor
// pushed to the transmit datapath, followed by a memory-to-stream read of
// the frame data. Every popped cookie is answered with exactly one
// completion cookie that carries a status code:
//   0 = sent, 1 = zero length, 2 = longer than MAX_LEN.
//
// Ports (the FIFO and engine bundles are flattened into plain signals):
//   clock                     rising-edge clock
//   resetn                    synchronous active-low reset
//   i_cookie_fifo_r_empty     TX cookie FIFO empty (first-word-fall-through)
//   i_cookie_fifo_r_rd_data   {addr[31:0], data_addr[31:0], size, sof, eof, no_crc}
//   i_cookie_fifo_r_rd_en     one-cycle pop pulse
//   meta_desc_fifo_w_full     meta descriptor FIFO full
//   meta_desc_fifo_w_wr_en    one-cycle push pulse
//   meta_desc_fifo_w_wr_data  {size, sof, eof, no_crc}
//   o_cookie_fifo_w_full      completion FIFO full
//   o_cookie_fifo_w_wr_en     one-cycle push pulse
//   o_cookie_fifo_w_wr_data   {addr[31:0], data_addr[31:0], size, status[1:0]}
//   tx_data_mem_r_start       one-cycle DMA start pulse
//   tx_data_mem_r_addr        DMA source address, held until the next start
//   tx_data_mem_r_len         DMA length in bytes, held until the next start
//   tx_data_mem_r_busy        DMA engine busy
// ---------------------------------------------------------------------------
module prism_sp_puzzle_hw_gem_dma_read #(
  parameter int MAX_LEN    = 16383,
  parameter int SIZE_WIDTH = 14
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     i_cookie_fifo_r_empty,
  input  logic [SIZE_WIDTH+66:0]   i_cookie_fifo_r_rd_data,
  output logic                     i_cookie_fifo_r_rd_en,
  input  logic                     meta_desc_fifo_w_full,
  output logic                     meta_desc_fifo_w_wr_en,
  output logic [SIZE_WIDTH+2:0]    meta_desc_fifo_w_wr_data,
  input  logic                     o_cookie_fifo_w_full,
  output logic                     o_cookie_fifo_w_wr_en,
  output logic [SIZE_WIDTH+65:0]   o_cookie_fifo_w_wr_data,
  output logic                     tx_data_mem_r_start,
  output logic [31:0]              tx_data_mem_r_addr,
  output logic [SIZE_WIDTH-1:0]    tx_data_mem_r_len,
  input  logic                     tx_data_mem_r_busy
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PREBUSY,
    BUSY,
    COMPLETE
  } state_t;

  state_t state, state_next;

  // Cookie fields captured at pop time; they feed every downstream output.
  logic [31:0]           addr_q;
  logic [31:0]           data_addr_q;
  logic [SIZE_WIDTH-1:0] size_q;
  logic                  sof_q;
  logic                  eof_q;
  logic                  no_crc_q;
  logic [1:0]            status_q;
  logic [31:0]           mem_addr_q;
  logic [SIZE_WIDTH-1:0] mem_len_q;

  // Registered pulses and their next-cycle values.
  logic rd_en_q, meta_wr_en_q, start_q, cpl_wr_en_q;
  logic rd_en_d, meta_wr_en_d, start_d, cpl_wr_en_d;

  logic [31:0] size_ext;
  logic        size_zero;
  logic        size_over;
  logic        pop;
  logic        meta_go;
  logic        cpl_go;

  assign size_ext  = 32'(size_q);
  assign size_zero = (size_q == '0);
  assign size_over = (size_ext > 32'(MAX_LEN));

  // Decisions shared by the next-state and output logic. A valid frame only
  // leaves CHECK once the meta FIFO can take its descriptor, so the DMA
  // start can never overtake the descriptor.
  assign pop     = (state == IDLE) && !i_cookie_fifo_r_empty;
  assign meta_go = (state == CHECK) && !size_zero && !size_over && !meta_desc_fifo_w_full;
  assign cpl_go  = ((state == BUSY) && !tx_data_mem_r_busy && !o_cookie_fifo_w_full) ||
                   ((state == COMPLETE) && !o_cookie_fifo_w_full);

  // State register. The pulses are registered as well, so every output is
  // glitch-free and reset forces all of them low in the following cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      rd_en_q      <= 1'b0;
      meta_wr_en_q <= 1'b0;
      start_q      <= 1'b0;
      cpl_wr_en_q  <= 1'b0;
    end else begin
      state        <= state_next;
      rd_en_q      <= rd_en_d;
      meta_wr_en_q <= meta_wr_en_d;
      start_q      <= start_d;
      cpl_wr_en_q  <= cpl_wr_en_d;
    end
  end

  // Next-state logic. PREBUSY gives the engine one cycle to raise busy
  // before BUSY starts watching for it to fall.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (pop) state_next = CHECK;
      CHECK: begin
        if (size_zero || size_over) state_next = COMPLETE;
        else if (meta_go)           state_next = PREBUSY;
      end
      PREBUSY:  state_next = BUSY;
      BUSY: begin
        if (!tx_data_mem_r_busy)
          state_next = o_cookie_fifo_w_full ? COMPLETE : IDLE;
      end
      COMPLETE: if (!o_cookie_fifo_w_full) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic: values the pulses take in the next cycle.
  always_comb begin
    rd_en_d      = pop;
    meta_wr_en_d = meta_go;
    start_d      = meta_go;
    cpl_wr_en_d  = cpl_go;
  end

  // Datapath registers. They need no reset: their contents are only
  // consumed after a pop has filled them.
  always_ff @(posedge clock) begin
    if (pop)
      {addr_q, data_addr_q, size_q, sof_q, eof_q, no_crc_q} <= i_cookie_fifo_r_rd_data;
    if (state == CHECK)
      status_q <= size_zero ? 2'd1 : (size_over ? 2'd2 : 2'd0);
    if (meta_go) begin
      mem_addr_q <= data_addr_q;
      mem_len_q  <= size_q;
    end
  end

  assign i_cookie_fifo_r_rd_en    = rd_en_q;
  assign meta_desc_fifo_w_wr_en   = meta_wr_en_q;
  assign meta_desc_fifo_w_wr_data = {size_q, sof_q, eof_q, no_crc_q};
  assign o_cookie_fifo_w_wr_en    = cpl_wr_en_q;
  assign o_cookie_fifo_w_wr_data  = {addr_q, data_addr_q, size_q, status_q};
  assign tx_data_mem_r_start      = start_q;
  assign tx_data_mem_r_addr       = mem_addr_q;
  assign tx_data_mem_r_len        = mem_len_q;

endmodule
